// File: rtl/obstacle_line_scheduler_if.sv
// obstacle_line_scheduler_if
// Bundles the line-timing inputs, the packed obstacle list and the active
// slot outputs of the scanline obstacle scheduler.
//   slave  : scheduler side (timing + obstacle list in, slots + status out)
//   master : pixel-generator / timing side (the mirror image)
// With SCHED_STATS_EN defined the bundle also carries overflow_cnt and
// late_cnt.
interface obstacle_line_scheduler_if #(
  parameter int OBSTACLE_NUM    = 7,
  parameter int SLOT_NUM        = 4,
  parameter int PHY_WIDTH       = 14,
  parameter int SCREEN_WIDTH    = 10,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int ROW_WIDTH       = 5
);
  logic                                  line_start;
  logic [SCREEN_WIDTH-1:0]               next_y;
  logic [PHY_WIDTH-1:0]                  camera_offset;
  logic                                  line_commit;
  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]     obstacle_abs_pos_x;
  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]     obstacle_abs_pos_y;
  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obstacle_block_width;

  logic [SLOT_NUM-1:0]                   slot_valid;
  logic [SLOT_NUM*PHY_WIDTH-1:0]         slot_x;
  logic [SLOT_NUM*ROW_WIDTH-1:0]         slot_row;
  logic [SLOT_NUM*BLOCK_LEN_WIDTH-1:0]   slot_width;
  logic                                  busy;
  logic                                  done;
  logic                                  overflow;
  logic                                  late;
`ifdef SCHED_STATS_EN
  logic [15:0]                           overflow_cnt;
  logic [15:0]                           late_cnt;
`endif

  modport slave (
    input  line_start, next_y, camera_offset, line_commit,
           obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_block_width,
    output slot_valid, slot_x, slot_row, slot_width,
           busy, done, overflow, late
`ifdef SCHED_STATS_EN
    , output overflow_cnt, late_cnt
`endif
  );

  modport master (
    output line_start, next_y, camera_offset, line_commit,
           obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_block_width,
    input  slot_valid, slot_x, slot_row, slot_width,
           busy, done, overflow, late
`ifdef SCHED_STATS_EN
    , input overflow_cnt, late_cnt
`endif
  );
endinterface

// File: rtl/obstacle_line_scheduler.sv
// obstacle_line_scheduler
// During hblank, walks the obstacle list one entry per cycle and collects up
// to SLOT_NUM obstacles that intersect the upcoming line (lowest index first)
// into shadow slots. line_commit copies the shadow slots to the active slot
// outputs, so the pixel path only compares SLOT_NUM entries.
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   bus (slave)        : line_start/next_y/camera_offset/line_commit and the
//                        packed obstacle list in; slot_* active slots,
//                        busy/done/overflow/late status out
// Optional: `define SCHED_STATS_EN adds saturating overflow_cnt/late_cnt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for line_start; shadow holds last completed scan
// ST_SCAN  | testing obstacle idx_q against abs_line_q, one per cycle
// ST_DONE  | single-cycle done pulse, shadow ready for commit
module obstacle_line_scheduler #(
  parameter int OBSTACLE_NUM    = 7,
  parameter int SLOT_NUM        = 4,
  parameter int PHY_WIDTH       = 14,
  parameter int SCREEN_WIDTH    = 10,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int OBSTACLE_HEIGHT = 20,
  parameter int ROW_WIDTH       = 5
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  obstacle_line_scheduler_if.slave  bus
);

  localparam int IDX_W = (OBSTACLE_NUM > 1) ? $clog2(OBSTACLE_NUM) : 1;
  localparam int CNT_W = $clog2(SLOT_NUM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(OBSTACLE_NUM - 1);
  localparam logic [CNT_W-1:0] SLOT_FULL = CNT_W'(SLOT_NUM);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PHY_WIDTH-1:0]       abs_line_q, abs_line_d;
  logic                       ready_q, ready_d;
  logic                       overflow_q, overflow_d;
  logic                       late_q, late_d;

  logic [SLOT_NUM-1:0]        sh_valid_q, sh_valid_d;
  logic [PHY_WIDTH-1:0]       sh_x_q [SLOT_NUM];
  logic [PHY_WIDTH-1:0]       sh_x_d [SLOT_NUM];
  logic [ROW_WIDTH-1:0]       sh_row_q [SLOT_NUM];
  logic [ROW_WIDTH-1:0]       sh_row_d [SLOT_NUM];
  logic [BLOCK_LEN_WIDTH-1:0] sh_w_q [SLOT_NUM];
  logic [BLOCK_LEN_WIDTH-1:0] sh_w_d [SLOT_NUM];

  logic [SLOT_NUM-1:0]        act_valid_q, act_valid_d;
  logic [PHY_WIDTH-1:0]       act_x_q [SLOT_NUM];
  logic [PHY_WIDTH-1:0]       act_x_d [SLOT_NUM];
  logic [ROW_WIDTH-1:0]       act_row_q [SLOT_NUM];
  logic [ROW_WIDTH-1:0]       act_row_d [SLOT_NUM];
  logic [BLOCK_LEN_WIDTH-1:0] act_w_q [SLOT_NUM];
  logic [BLOCK_LEN_WIDTH-1:0] act_w_d [SLOT_NUM];

  logic [PHY_WIDTH-1:0]       cur_x;
  logic [PHY_WIDTH-1:0]       cur_y;
  logic [BLOCK_LEN_WIDTH-1:0] cur_w;
  logic [PHY_WIDTH:0]         cur_y_end;
  logic [ROW_WIDTH-1:0]       cur_row;
  logic                       hit;
  logic                       busy;

  assign busy = (state_q == ST_SCAN);

  // Obstacle under test this cycle.
  always_comb begin
    cur_x = '0;
    cur_y = '0;
    cur_w = '0;
    for (int i = 0; i < OBSTACLE_NUM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_x = bus.obstacle_abs_pos_x[i*PHY_WIDTH +: PHY_WIDTH];
        cur_y = bus.obstacle_abs_pos_y[i*PHY_WIDTH +: PHY_WIDTH];
        cur_w = bus.obstacle_block_width[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
      end
    end
  end

  // One extra bit on the bottom edge: an obstacle near the top of the
  // coordinate space must not wrap around and claim lines near zero.
  assign cur_y_end = {1'b0, cur_y} + (PHY_WIDTH+1)'(OBSTACLE_HEIGHT);
  assign hit       = (cur_w != '0) && (abs_line_q >= cur_y) &&
                     ({1'b0, abs_line_q} < cur_y_end);
  assign cur_row   = ROW_WIDTH'(abs_line_q - cur_y);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    abs_line_d  = abs_line_q;
    ready_d     = ready_q;
    overflow_d  = overflow_q;
    late_d      = late_q;
    sh_valid_d  = sh_valid_q;
    sh_x_d      = sh_x_q;
    sh_row_d    = sh_row_q;
    sh_w_d      = sh_w_q;
    act_valid_d = act_valid_q;
    act_x_d     = act_x_q;
    act_row_d   = act_row_q;
    act_w_d     = act_w_q;

    // Commit looks only at pre-edge ready/shadow; a coincident line_start
    // below may then restart the scan.
    if (bus.line_commit) begin
      if (ready_q) begin
        act_valid_d = sh_valid_q;
        act_x_d     = sh_x_q;
        act_row_d   = sh_row_q;
        act_w_d     = sh_w_q;
      end else begin
        act_valid_d = '0;
        late_d      = 1'b1;
      end
    end

    if (bus.line_start) begin
      abs_line_d = PHY_WIDTH'(bus.next_y) + bus.camera_offset;
      sh_valid_d = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
      late_d     = busy;
      ready_d    = 1'b0;
      idx_d      = '0;
      state_d    = ST_SCAN;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SCAN: begin
          if (hit) begin
            if (cnt_q != SLOT_FULL) begin
              for (int s = 0; s < SLOT_NUM; s++) begin
                if (cnt_q == CNT_W'(s)) begin
                  sh_valid_d[s] = 1'b1;
                  sh_x_d[s]     = cur_x;
                  sh_row_d[s]   = cur_row;
                  sh_w_d[s]     = cur_w;
                end
              end
              cnt_d = cnt_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      abs_line_q  <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      late_q      <= 1'b0;
      sh_valid_q  <= '0;
      act_valid_q <= '0;
      for (int s = 0; s < SLOT_NUM; s++) begin
        sh_x_q[s]    <= '0;
        sh_row_q[s]  <= '0;
        sh_w_q[s]    <= '0;
        act_x_q[s]   <= '0;
        act_row_q[s] <= '0;
        act_w_q[s]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      abs_line_q  <= abs_line_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      late_q      <= late_d;
      sh_valid_q  <= sh_valid_d;
      act_valid_q <= act_valid_d;
      for (int s = 0; s < SLOT_NUM; s++) begin
        sh_x_q[s]    <= sh_x_d[s];
        sh_row_q[s]  <= sh_row_d[s];
        sh_w_q[s]    <= sh_w_d[s];
        act_x_q[s]   <= act_x_d[s];
        act_row_q[s] <= act_row_d[s];
        act_w_q[s]   <= act_w_d[s];
      end
    end
  end

  for (genvar g = 0; g < SLOT_NUM; g++) begin : g_slot_out
    assign bus.slot_valid[g]                                     = act_valid_q[g];
    assign bus.slot_x[g*PHY_WIDTH +: PHY_WIDTH]                   = act_x_q[g];
    assign bus.slot_row[g*ROW_WIDTH +: ROW_WIDTH]                 = act_row_q[g];
    assign bus.slot_width[g*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH]   = act_w_q[g];
  end

  assign bus.busy     = busy;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = overflow_q;
  assign bus.late     = late_q;

`ifdef SCHED_STATS_EN
  logic [15:0] overflow_cnt_q, overflow_cnt_d;
  logic [15:0] late_cnt_q, late_cnt_d;
  logic        ovf_evt;
  logic        late_evt;

  // Count only the transition of each sticky flag into the set state for
  // the current scan; a restart while busy is a fresh scan and counts again.
  assign ovf_evt  = !bus.line_start && busy && hit &&
                    (cnt_q == SLOT_FULL) && !overflow_q;
  assign late_evt = bus.line_start ? busy
                                   : (bus.line_commit && !ready_q && !late_q);

  always_comb begin
    overflow_cnt_d = overflow_cnt_q;
    late_cnt_d     = late_cnt_q;
    if (ovf_evt && (overflow_cnt_q != 16'hFFFF))
      overflow_cnt_d = overflow_cnt_q + 16'd1;
    if (late_evt && (late_cnt_q != 16'hFFFF))
      late_cnt_d = late_cnt_q + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      overflow_cnt_q <= '0;
      late_cnt_q     <= '0;
    end else begin
      overflow_cnt_q <= overflow_cnt_d;
      late_cnt_q     <= late_cnt_d;
    end
  end

  assign bus.overflow_cnt = overflow_cnt_q;
  assign bus.late_cnt     = late_cnt_q;
`endif

endmodule
